btn_event_encoder: RTL and testbench
====================================

// Module: btn_event_encoder
// PURPOSE
//  Front-end for the Simon game FSM. Takes the 4 raw push-buttons (BTNU, BTNL, BTNR, BTND)
//  and produces one event per press episode: a 2-bit button code with a valid/ready handshake.
//  Synchronises, debounces (sampled on a tick enable), detects presses and priority-encodes.
//  The simon FSM consumes evt_valid/evt_val directly.
// PARAMETERS
//  N_BTN        4    number of buttons; the 2-bit code width is fixed for N_BTN=4
//  DEB_TICKS    4    consecutive identical tick samples needed to flip a debounced level (>=2)
//  STUCK_TICKS  500  ticks a level may stay high before stuck is flagged (BTN_EVT_STUCK_EN only)
// PORTS
//  clk        in   1      system clock, 100 MHz
//  reset_n    in   1      asynchronous, active-low reset
//  tick       in   1      sample enable, one clk wide (~100 Hz in system; tie high in sim)
//  btn        in   4      raw buttons, active-high, asynchronous; bit0=U 1=L 2=R 3=D
//  evt_ready  in   1      consumer accepts the event this cycle
//  ovf_clr    in   1      clears the overflow flag
//  evt_valid  out  1      an event is pending
//  evt_val    out  2      button code of the pending event; stable while evt_valid=1
//  held       out  4      debounced button levels (for LED echo)
//  overflow   out  1      sticky: an event was dropped
//  stuck      out  1      a button has been held too long (0 when BTN_EVT_STUCK_EN is undefined)
// BEHAVIOUR
//  Reset: all outputs are 0, counters and sync flops are 0, FSM is S_IDLE. Reset takes effect
//   asynchronously at any point; any pending event is discarded.
//  Sync: 2-FF synchroniser per bit on every clk. Debounce logic sees the sync output only.
//  Debounce (per bit, updates only on tick=1):
//   - Sample equals held[k]: cnt <= 0.
//   - Sample differs and cnt == DEB_TICKS-1: held[k] toggles and cnt <= 0.
//   - Otherwise: cnt++.
//   - A glitch shorter than DEB_TICKS ticks never changes held.
//  Event FSM (evaluated every clk, on the registered held):
//   - S_IDLE:  held!=0 -> raise an event for the lowest set bit and go to S_HELD.
//   - S_HELD:  held==0 -> go to S_IDLE. No other events are raised.
//   - Chords and extra buttons pressed while one is held are therefore ignored. Each release
//     of all buttons followed by a press gives exactly one event.
//  Latency: the event is raised the clk after held goes non-zero. evt_valid rises the clk
//   after the event is raised.
//  Handshake:
//   - evt_valid stays high until a cycle with evt_valid & evt_ready; it then clears next clk.
//   - Event raised while the slot is empty, or in the same cycle as an accept: it is loaded
//     and evt_valid stays/goes 1.
//   - Event raised while evt_valid=1 & evt_ready=0: the new event is dropped, the old one is
//     kept, overflow <= 1.
//   - overflow clears only on ovf_clr=1 or reset. Set wins over clear in the same cycle.
// CONFIGURATION
//  Macro BTN_EVT_STUCK_EN.
//  - Defined: a per-design tick counter runs while held!=0 and saturates at STUCK_TICKS.
//    stuck=1 while count==STUCK_TICKS. The counter and stuck clear when held==0.
//  - Undefined: no counter is built and stuck is tied to 0.
// STRUCTURE
//  Shared package simon_pkg holds:
//   - button codes BTN_U=0, BTN_L=1, BTN_R=2, BTN_D=3
//   - event FSM state encoding S_IDLE/S_HELD
//   - default DEB_TICKS.
//  Sub-module btn_debounce_cell (sync + counter + level for one bit), instantiated N_BTN
//  times via generate. Priority encoder, event FSM, output slot and stuck logic live in the top.
// TESTING  (tick=1 every clk unless stated; DEB_TICKS=4)
//  1. btn=0001, held steady -> held[0]=1 after 2 sync + 4 ticks; evt_valid=1, evt_val=0 two
//     clks later. evt_ready=1 -> evt_valid=0 next clk. No second event while held.
//  2. btn[2] high for 3 clks, then low -> held stays 0000, no event.
//  3. btn=1010 at once -> one event, evt_val=1 (L). Releasing bit1 only while bit3 stays
//     held -> no event. Release all, press 1000 -> evt_val=3.
//  4. evt_ready=0. Press/release U, then press/release D -> evt_val stays 0 and overflow=1.
//     evt_ready=1 -> valid clears, overflow stays 1. ovf_clr=1 -> overflow=0.
//  5. reset_n low mid-press with evt_valid=1 -> all outputs 0 immediately. After release,
//     held bits re-debounce from 0000.
//  6. With BTN_EVT_STUCK_EN and STUCK_TICKS=10: hold U for 20 ticks -> stuck=1 from tick 10
//     after held rises; release -> stuck=0. Without the macro, stuck stays 0.

Source files
------------

// File: rtl/simon_pkg.sv
// Shared definitions for the Simon game front-end: button codes, event FSM
// state encoding, default debounce depth and a priority-encode helper.
package simon_pkg;

    // Button codes as seen by the Simon FSM (bit index of the raw button bus)
    localparam logic [1:0] BTN_U = 2'd0;
    localparam logic [1:0] BTN_L = 2'd1;
    localparam logic [1:0] BTN_R = 2'd2;
    localparam logic [1:0] BTN_D = 2'd3;

    // Default number of consecutive identical tick samples to flip a level
    localparam int DEB_TICKS_DEF = 4;

    // Event FSM states: waiting for a press, or waiting for a full release
    typedef enum logic {
        S_IDLE = 1'b0,
        S_HELD = 1'b1
    } evt_state_t;

    // Lowest set bit wins: U beats L beats R beats D
    function automatic logic [1:0] lowest_set(input logic [3:0] levels);
        logic [1:0] code;
        code = BTN_U;
        if (levels[0])      code = BTN_U;
        else if (levels[1]) code = BTN_L;
        else if (levels[2]) code = BTN_R;
        else if (levels[3]) code = BTN_D;
        return code;
    endfunction

endpackage

// File: rtl/btn_debounce_cell.sv
// One button channel: 2-FF synchroniser followed by a tick-sampled debounce
// counter. The debounced level flips only after DEB_TICKS consecutive tick
// samples that disagree with it; any agreeing sample restarts the count.
module btn_debounce_cell
    import simon_pkg::*;
#(
    parameter int DEB_TICKS = DEB_TICKS_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tick,
    input  logic raw,
    output logic level
);

    localparam int CW = (DEB_TICKS > 2) ? $clog2(DEB_TICKS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_TICKS - 1);

    logic          sync_1;
    logic          sync_2;
    logic [CW-1:0] cnt;

    // Two-stage synchroniser for the asynchronous raw button
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
        end
    end

    // Count disagreeing tick samples; flip the level on the last one
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (tick) begin
            if (sync_2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/btn_event_encoder.sv
// Button front-end for the Simon game: debounces the four raw buttons,
// raises one event per press episode (lowest set button wins) and holds it
// in a one-entry output slot.
//
// Handshake: evt_valid/evt_val form a valid/ready slot. Once evt_valid is
// high, evt_val is stable and evt_valid stays high until a cycle with
// evt_valid & evt_ready; the slot empties on the following clock unless a
// new event is loaded in that same cycle. An event arriving while the slot
// is full and not being accepted is dropped and flags the sticky overflow.
//
// Optional feature: define BTN_EVT_STUCK_EN to build the held-too-long
// detector; otherwise stuck is tied low.
module btn_event_encoder
    import simon_pkg::*;
#(
    parameter int N_BTN       = 4,
    parameter int DEB_TICKS   = DEB_TICKS_DEF,
    parameter int STUCK_TICKS = 500
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             tick,
    input  logic [N_BTN-1:0] btn,
    input  logic             evt_ready,
    input  logic             ovf_clr,
    output logic             evt_valid,
    output logic [1:0]       evt_val,
    output logic [N_BTN-1:0] held,
    output logic             overflow,
    output logic             stuck,
    output evt_state_t       fsm_state
);

    // Elaboration-time parameter sanity
    if (N_BTN != 4) begin : g_bad_nbtn
        $error("btn_event_encoder: the 2-bit code needs N_BTN == 4");
    end
    if (DEB_TICKS < 2) begin : g_bad_deb
        $error("btn_event_encoder: DEB_TICKS must be at least 2");
    end
    if (STUCK_TICKS < 1) begin : g_bad_stuck
        $error("btn_event_encoder: STUCK_TICKS must be at least 1");
    end

    logic       raise;
    logic [1:0] raise_code;
    logic       ovf_set;

    // One sync+debounce channel per button
    for (genvar k = 0; k < N_BTN; k++) begin : g_cell
        btn_debounce_cell #(
            .DEB_TICKS (DEB_TICKS)
        ) u_cell (
            .clk     (clk),
            .reset_n (reset_n),
            .tick    (tick),
            .raw     (btn[k]),
            .level   (held[k])
        );
    end

    // Event FSM: one registered event pulse per release-to-press episode
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm_state  <= S_IDLE;
            raise      <= 1'b0;
            raise_code <= BTN_U;
        end else begin
            raise <= 1'b0;
            case (fsm_state)
                S_IDLE: begin
                    if (held != '0) begin
                        raise      <= 1'b1;
                        raise_code <= lowest_set(held);
                        fsm_state  <= S_HELD;
                    end
                end
                S_HELD: begin
                    if (held == '0) begin
                        fsm_state <= S_IDLE;
                    end
                end
                default: fsm_state <= S_IDLE;
            endcase
        end
    end

    // A new event is lost only when the slot is full and not draining
    assign ovf_set = raise & evt_valid & ~evt_ready;

    // Output slot: load on raise when empty or draining, clear on accept
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            evt_valid <= 1'b0;
            evt_val   <= 2'd0;
        end else if (raise && (!evt_valid || evt_ready)) begin
            evt_valid <= 1'b1;
            evt_val   <= raise_code;
        end else if (evt_valid && evt_ready) begin
            evt_valid <= 1'b0;
        end
    end

    // Sticky overflow; a set in the same cycle beats the clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (ovf_set) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

`ifdef BTN_EVT_STUCK_EN
    localparam int SW = $clog2(STUCK_TICKS + 1);
    localparam logic [SW-1:0] STUCK_MAX = SW'(STUCK_TICKS);

    logic [SW-1:0] stuck_cnt;

    // Count ticks while any button is held, saturating at the limit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stuck_cnt <= '0;
        end else if (held == '0) begin
            stuck_cnt <= '0;
        end else if (tick && stuck_cnt != STUCK_MAX) begin
            stuck_cnt <= stuck_cnt + 1'b1;
        end
    end

    assign stuck = (stuck_cnt == STUCK_MAX);
`else
    assign stuck = 1'b0;
`endif

endmodule

// File: tb/tb_btn_event_encoder.sv
// Self-checking bench for btn_event_encoder: directed scenarios followed by
// randomized press episodes, all compared each cycle against a behavioural
// model of the button/event rules.
module tb_btn_event_encoder;
  import simon_pkg::*;

  localparam int DEB = 4;
  localparam int ST  = 500;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       tick;
  logic [3:0] btn;
  logic       evt_ready;
  logic       ovf_clr;
  logic       evt_valid;
  logic [1:0] evt_val;
  logic [3:0] held;
  logic       overflow;
  logic       stuck;
  evt_state_t fsm_state;

  int n_checks = 0;
  int n_fail   = 0;

  // clock / reset block
  always #5 clk = ~clk;

  btn_event_encoder #(
    .N_BTN       (4),
    .DEB_TICKS   (DEB),
    .STUCK_TICKS (ST)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .tick      (tick),
    .btn       (btn),
    .evt_ready (evt_ready),
    .ovf_clr   (ovf_clr),
    .evt_valid (evt_valid),
    .evt_val   (evt_val),
    .held      (held),
    .overflow  (overflow),
    .stuck     (stuck),
    .fsm_state (fsm_state)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // btn delayed by the synchroniser, per-bit run of disagreeing samples,
  // an "armed" flag meaning all buttons were released since the last event,
  // and the one-entry slot.
  logic [3:0] d1, d2;
  int         run [4];
  logic [3:0] m_held;
  logic       m_armed;
  logic       m_raise;
  logic [1:0] m_code;
  logic       m_valid;
  logic [1:0] m_val;
  logic       m_ovf;
  int         m_scnt;
  logic [1:0] exp_q[$];

  logic [3:0] n_held;
  logic       n_raise, n_armed, n_valid, n_ovf;
  logic [1:0] n_code, n_val;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d1 = '0; d2 = '0;
      for (int k = 0; k < 4; k++) run[k] = 0;
      m_held = '0; m_armed = 1'b1; m_raise = 1'b0; m_code = '0;
      m_valid = 1'b0; m_val = '0; m_ovf = 1'b0; m_scnt = 0;
      exp_q.delete();
    end else begin
      // debounce: DEB consecutive disagreeing ticks flip a level
      n_held = m_held;
      if (tick) begin
        for (int k = 0; k < 4; k++) begin
          if (d2[k] != m_held[k]) begin
            run[k] = run[k] + 1;
            if (run[k] == DEB) begin
              n_held[k] = ~m_held[k];
              run[k] = 0;
            end
          end else begin
            run[k] = 0;
          end
        end
      end
      // one event for the first non-zero held after a full release
      n_raise = m_armed && (m_held != 0);
      n_code  = m_code;
      if (n_raise) begin
        for (int k = 3; k >= 0; k--) if (m_held[k]) n_code = 2'(k);
      end
      n_armed = m_armed;
      if (m_held == 0) n_armed = 1'b1;
      else if (n_raise) n_armed = 1'b0;
      // slot
      n_valid = m_valid; n_val = m_val; n_ovf = m_ovf;
      if (m_raise && (!m_valid || evt_ready)) begin
        n_valid = 1'b1; n_val = m_code; exp_q.push_back(m_code);
      end else if (m_valid && evt_ready) begin
        n_valid = 1'b0;
      end
      if (m_raise && m_valid && !evt_ready) n_ovf = 1'b1;
      else if (ovf_clr) n_ovf = 1'b0;
      // held-too-long counter
      if (m_held == 0) m_scnt = 0;
      else if (tick && m_scnt < ST) m_scnt = m_scnt + 1;
      // commit
      d2 = d1; d1 = btn;
      m_held = n_held; m_raise = n_raise; m_code = n_code; m_armed = n_armed;
      m_valid = n_valid; m_val = n_val; m_ovf = n_ovf;
    end
  end

  function automatic logic exp_stuck();
`ifdef BTN_EVT_STUCK_EN
    return (m_scnt == ST);
`else
    return 1'b0;
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic compare_all();
    check_eq("evt_valid", 32'(evt_valid), 32'(m_valid));
    check_eq("evt_val",   32'(evt_val),   32'(m_val));
    check_eq("held",      32'(held),      32'(m_held));
    check_eq("overflow",  32'(overflow),  32'(m_ovf));
    check_eq("stuck",     32'(stuck),     32'(exp_stuck()));
  endtask

  // compare the state left by the last edge, then drive the next cycle
  task automatic cycle(input logic [3:0] b, input logic r, input logic c, input logic t);
    logic [1:0] e;
    @(negedge clk);
    compare_all();
    btn = b; evt_ready = r; ovf_clr = c; tick = t;
    if (evt_valid && evt_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("accept_unexpected", 32'(evt_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("accept_code", 32'(evt_val), 32'(e));
      end
    end
  endtask

  task automatic hold(input logic [3:0] b, input logic r, input int n);
    for (int i = 0; i < n; i++) cycle(b, r, 1'b0, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0; btn = '0; tick = 1'b1; evt_ready = 1'b0; ovf_clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_valid", 32'(evt_valid), 32'd0);
    check_eq("rst_val",   32'(evt_val),   32'd0);
    check_eq("rst_held",  32'(held),      32'd0);
    check_eq("rst_ovf",   32'(overflow),  32'd0);
    check_eq("rst_stuck", 32'(stuck),     32'd0);
    reset_n = 1'b1;

    // 1: U press, latency, accept, no repeat while held
    hold(4'b0000, 1'b0, 3);
    cycle(4'b0001, 1'b0, 1'b0, 1'b1);
    hold(4'b0001, 1'b0, 5);
    check_eq("t1_held_early", 32'(held), 32'd0);
    hold(4'b0001, 1'b0, 1);
    check_eq("t1_held_up", 32'(held), 32'd1);
    hold(4'b0001, 1'b0, 1);
    check_eq("t1_valid_early", 32'(evt_valid), 32'd0);
    hold(4'b0001, 1'b0, 1);
    check_eq("t1_valid", 32'(evt_valid), 32'd1);
    check_eq("t1_code", 32'(evt_val), 32'(BTN_U));
    hold(4'b0001, 1'b1, 1);
    hold(4'b0001, 1'b0, 1);
    check_eq("t1_cleared", 32'(evt_valid), 32'd0);
    hold(4'b0001, 1'b0, 12);
    check_eq("t1_no_repeat", 32'(evt_valid), 32'd0);
    hold(4'b0000, 1'b1, 10);

    // 2: short glitch on R
    hold(4'b0100, 1'b1, 3);
    hold(4'b0000, 1'b1, 10);
    check_eq("t2_held", 32'(held), 32'd0);

    // 3: chord, partial release, then D
    hold(4'b1010, 1'b0, 10);
    check_eq("t3_code_l", 32'(evt_val), 32'(BTN_L));
    hold(4'b1010, 1'b1, 1);
    hold(4'b1000, 1'b0, 12);
    check_eq("t3_no_evt", 32'(evt_valid), 32'd0);
    hold(4'b0000, 1'b0, 10);
    hold(4'b1000, 1'b0, 10);
    check_eq("t3_code_d", 32'(evt_val), 32'(BTN_D));
    hold(4'b1000, 1'b1, 1);
    hold(4'b0000, 1'b0, 10);

    // 4: overflow with a stalled consumer
    hold(4'b0001, 1'b0, 10);
    hold(4'b0000, 1'b0, 10);
    hold(4'b1000, 1'b0, 10);
    hold(4'b0000, 1'b0, 4);
    check_eq("t4_kept", 32'(evt_val), 32'(BTN_U));
    check_eq("t4_ovf", 32'(overflow), 32'd1);
    hold(4'b0000, 1'b1, 1);
    hold(4'b0000, 1'b0, 2);
    check_eq("t4_ovf_sticky", 32'(overflow), 32'd1);
    cycle(4'b0000, 1'b0, 1'b1, 1'b1);
    hold(4'b0000, 1'b0, 2);
    check_eq("t4_ovf_clr", 32'(overflow), 32'd0);

    // 5: asynchronous reset mid-press with an event pending
    hold(4'b0100, 1'b0, 10);
    check_eq("t5_pending", 32'(evt_valid), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("t5_rst_valid", 32'(evt_valid), 32'd0);
    check_eq("t5_rst_held",  32'(held),      32'd0);
    check_eq("t5_rst_val",   32'(evt_val),   32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    hold(4'b0000, 1'b1, 10);
    hold(4'b0010, 1'b1, 12);
    hold(4'b0000, 1'b1, 10);

    // 6: long hold (exercises the stuck detector when built)
    hold(4'b0001, 1'b0, ST + 20);
    hold(4'b0000, 1'b1, 10);

    // random episodes
    for (int ep = 0; ep < 250; ep++) begin
      logic [3:0] pat;
      int len;
      pat = 4'($urandom_range(0, 15));
      len = $urandom_range(1, 14);
      for (int i = 0; i < len; i++) begin
        cycle(pat, ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
              ($urandom_range(0, 7) != 0));
      end
    end
    hold(4'b0000, 1'b1, 20);
    check_eq("end_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
